// File: rtl/rgmii_rx_frame_receiver.sv
// rgmii_rx_frame_receiver
// Receive side of an RGMII port. Captures the DDR nibbles on both edges of
// the receive clock, rebuilds bytes, strips preamble/SFD and delivers the
// frame as a byte stream with first/last/error framing. Only length and
// in-frame RX_ER are checked here; FCS is left to downstream logic.
//
// Ports
//   clock            RGMII RXC, both edges used for capture
//   reset_n          asynchronous active-low reset
//   rgmii_rxd        DDR receive data (low nibble on rise, high on fall)
//   rgmii_rx_ctl     DDR control (RX_DV on rise, RX_DV^RX_ER on fall)
//   rx_data          received payload byte
//   rx_valid         rx_data valid this cycle (no backpressure)
//   rx_first         first byte after SFD
//   rx_last          final byte of frame
//   rx_error         frame bad, qualified by rx_last
//   good_frame_count frames ended without error (wrapping)
//   bad_frame_count  frames ended with error, including zero-length (wrapping)
//
// State | meaning
// IDLE     | waiting for RX_DV with a preamble or SFD byte
// PREAMBLE | inside 0x55 preamble, waiting for SFD 0xD5
// PAYLOAD  | receiving frame bytes, one byte held to mark the last one
// DROP     | unsyncable frame, discard until RX_DV drops

module rgmii_rx_frame_receiver #(
    parameter int INPUT_WIDTH     = 4,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [INPUT_WIDTH-1:0]   rgmii_rxd,
    input  logic                     rgmii_rx_ctl,
    output logic [2*INPUT_WIDTH-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     rx_first,
    output logic                     rx_last,
    output logic                     rx_error,
    output logic [15:0]              good_frame_count,
    output logic [15:0]              bad_frame_count
);

    localparam int BYTE_W = 2 * INPUT_WIDTH;
    localparam int LEN_W  = $clog2(MAX_FRAME_BYTES + 2);

    localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [LEN_W-1:0]  LEN_SAT  = LEN_W'(MAX_FRAME_BYTES + 1);
    localparam logic [BYTE_W-1:0] PRE_BYTE = BYTE_W'(8'h55);
    localparam logic [BYTE_W-1:0] SFD_BYTE = BYTE_W'(8'hD5);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [INPUT_WIDTH-1:0] rise_nibble;
    logic [INPUT_WIDTH-1:0] fall_nibble;
    logic                   dv;
    logic                   ctl2;

    logic [BYTE_W-1:0] byte_data;
    logic              byte_dv;
    logic              byte_er;

    logic [BYTE_W-1:0] hold_data;
    logic              hold_valid;
    logic              hold_first;
    logic [LEN_W-1:0]  len;
    logic              sticky_er;
    logic              frame_bad;

    logic start;
    logic store;
    logic finish;
    logic beat_valid;
    logic beat_first;
    logic beat_last;
    logic beat_error;

    // Rising-edge half of the DDR capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_nibble <= '0;
            dv          <= 1'b0;
        end else begin
            rise_nibble <= rgmii_rxd;
            dv          <= rgmii_rx_ctl;
        end
    end

    // Falling-edge half of the DDR capture.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fall_nibble <= '0;
            ctl2        <= 1'b0;
        end else begin
            fall_nibble <= rgmii_rxd;
            ctl2        <= rgmii_rx_ctl;
        end
    end

    // Byte assembly: the falling edge carries DV^ER, so ER is recovered by xor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_data <= '0;
            byte_dv   <= 1'b0;
            byte_er   <= 1'b0;
        end else begin
            byte_data <= {fall_nibble, rise_nibble};
            byte_dv   <= dv;
            byte_er   <= dv ^ ctl2;
        end
    end

    assign frame_bad = sticky_er | (len < LEN_MIN) | (len > LEN_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // byte_er is only looked at while byte_dv is high, so DV=0 with ER=1
    // (carrier extension / in-band status) behaves exactly like idle.
    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        store      = 1'b0;
        finish     = 1'b0;
        beat_valid = 1'b0;
        beat_first = 1'b0;
        beat_last  = 1'b0;
        beat_error = 1'b0;
        case (state)
            IDLE: begin
                if (byte_dv) begin
                    if (byte_data == PRE_BYTE) begin
                        state_nx = PREAMBLE;
                    end else if (byte_data == SFD_BYTE) begin
                        state_nx = PAYLOAD;
                        start    = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!byte_dv) begin
                    state_nx = IDLE;
                end else if (byte_data == SFD_BYTE) begin
                    state_nx = PAYLOAD;
                    start    = 1'b1;
                end else if (byte_data != PRE_BYTE) begin
                    state_nx = DROP;
                end
            end
            PAYLOAD: begin
                if (byte_dv) begin
                    store      = 1'b1;
                    beat_valid = hold_valid;
                    beat_first = hold_valid & hold_first;
                end else begin
                    finish     = 1'b1;
                    beat_valid = hold_valid;
                    beat_first = hold_valid & hold_first;
                    beat_last  = hold_valid;
                    beat_error = hold_valid & frame_bad;
                    state_nx   = IDLE;
                end
            end
            DROP: begin
                if (!byte_dv) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Frame datapath: one byte held back so the last byte can carry rx_last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_first <= 1'b0;
            len        <= '0;
            sticky_er  <= 1'b0;
        end else if (start) begin
            hold_valid <= 1'b0;
            hold_first <= 1'b0;
            len        <= '0;
            sticky_er  <= 1'b0;
        end else if (store) begin
            hold_data  <= byte_data;
            hold_valid <= 1'b1;
            hold_first <= (len == '0);
            if (len != LEN_SAT) begin
                len <= len + 1'b1;
            end
            if (byte_er) begin
                sticky_er <= 1'b1;
            end
        end else if (finish) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            rx_last  <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= beat_valid;
            rx_first <= beat_first;
            rx_last  <= beat_last;
            rx_error <= beat_error;
            if (beat_valid) begin
                rx_data <= hold_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            good_frame_count <= '0;
            bad_frame_count  <= '0;
        end else if (finish) begin
            if (frame_bad) begin
                bad_frame_count <= bad_frame_count + 16'd1;
            end else begin
                good_frame_count <= good_frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_frame_receiver.sv
// Self-checking bench for rgmii_rx_frame_receiver. Frames are driven as DDR
// nibbles; a frame-level model builds the expected beat list and counters,
// and a negedge monitor scores every delivered beat against that list.

module tb_rgmii_rx_frame_receiver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  rgmii_rxd;
    logic        rgmii_rx_ctl;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_first;
    logic        rx_last;
    logic        rx_error;
    logic [15:0] good_frame_count;
    logic [15:0] bad_frame_count;

    rgmii_rx_frame_receiver #(
        .INPUT_WIDTH(4),
        .MIN_FRAME_BYTES(64),
        .MAX_FRAME_BYTES(1522)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rgmii_rxd(rgmii_rxd),
        .rgmii_rx_ctl(rgmii_rx_ctl),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_first(rx_first),
        .rx_last(rx_last),
        .rx_error(rx_error),
        .good_frame_count(good_frame_count),
        .bad_frame_count(bad_frame_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_sample_cyc = 0;
    int sample_cyc = 0;
    int first_beat_cyc = 0;
    int beat_count = 0;
    int first_count = 0;
    int last_count = 0;

    logic [7:0]  pay[$];
    logic [10:0] exp_q[$];   // {data, first, last, error}
    logic [15:0] exp_good = 16'd0;
    logic [15:0] exp_bad = 16'd0;
    logic [10:0] mon_got;
    logic [10:0] mon_exp;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every beat must match the head of the model's beat list.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_valid) begin
                mon_got = {rx_data, rx_first, rx_last, rx_error};
                beat_count++;
                if (rx_first) begin
                    first_count++;
                    first_beat_cyc = cyc;
                end
                if (rx_last) last_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got=%h required=no beat", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL beat got=%h required=%h (data,first,last,error)", mon_got, mon_exp);
                    end
                end
            end else if (rx_first || rx_last || rx_error) begin
                checks++;
                errors++;
                $display("FAIL framing_without_valid got=%b%b%b required=000", rx_first, rx_last, rx_error);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit dv_b, input bit er_b);
        @(negedge clock); #1;
        rgmii_rxd    = d[3:0];
        rgmii_rx_ctl = dv_b;
        @(posedge clock); #1;
        last_sample_cyc = cyc;
        rgmii_rxd    = d[7:4];
        rgmii_rx_ctl = dv_b ^ er_b;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    // Drives pre_len preamble bytes, SFD, the bytes in pay, then gap idle
    // bytes (optionally with carrier extension) and updates the model.
    task automatic send_frame(input int pre_len, input int er_idx, input int gap, input bit ext);
        int  n;
        bit  bad;
        n   = pay.size();
        bad = (er_idx >= 0 && er_idx < n) || (n < 64) || (n > 1522);
        for (int i = 0; i < n; i++)
            exp_q.push_back({pay[i], i == 0, i == n - 1, (i == n - 1) && bad});
        if (bad) exp_bad++;
        else exp_good++;
        for (int i = 0; i < pre_len; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_byte(pay[i], 1'b1, i == er_idx);
            if (i == 0) sample_cyc = last_sample_cyc;
        end
        for (int i = 0; i < gap; i++) send_byte(8'($urandom), 1'b0, ext);
    endtask

    task automatic fill_counting(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(i));
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rgmii_rxd = 4'h0;
        rgmii_rx_ctl = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rx_data, rx_valid, rx_first, rx_last, rx_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=000", {rx_data, rx_valid, rx_first, rx_last, rx_error});
        end
        checks++;
        if ({good_frame_count, bad_frame_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters got=%h required=00000000", {good_frame_count, bad_frame_count});
        end
        @(negedge clock);
        reset_n = 1'b1;
        send_idle(4);
        checks++;
        if (beat_count !== 0) begin
            errors++;
            $display("FAIL idle_no_beats got=%0d required=0", beat_count);
        end
    endtask

    task automatic test_nominal_frame();
        int b0;
        b0 = beat_count;
        fill_counting(64);
        send_frame(7, -1, 1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 64) begin
            errors++;
            $display("FAIL nominal_beats got=%0d required=64", beat_count - b0);
        end
        checks++;
        if (first_beat_cyc - sample_cyc !== 3) begin
            errors++;
            $display("FAIL nominal_latency got=%0d required=3", first_beat_cyc - sample_cyc);
        end
        checks++;
        if (good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
            errors++;
            $display("FAIL nominal_counters got=%0d/%0d required=%0d/%0d", good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_rx_er();
        int b0;
        b0 = beat_count;
        fill_counting(64);
        send_frame(7, 10, 1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 64) begin
            errors++;
            $display("FAIL rx_er_beats got=%0d required=64", beat_count - b0);
        end
        checks++;
        if (good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
            errors++;
            $display("FAIL rx_er_counters got=%0d/%0d required=%0d/%0d", good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_length_bounds();
        int lens[5] = '{60, 1523, 1522, 63, 1};
        for (int k = 0; k < 5; k++) begin
            int b0;
            b0 = beat_count;
            fill_random(lens[k]);
            send_frame(7, -1, 1, 1'b0);
            send_idle(4);
            checks++;
            if (beat_count - b0 !== lens[k]) begin
                errors++;
                $display("FAIL length_beats len=%0d got=%0d required=%0d", lens[k], beat_count - b0, lens[k]);
            end
            checks++;
            if (good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
                errors++;
                $display("FAIL length_counters len=%0d got=%0d/%0d required=%0d/%0d", lens[k], good_frame_count, bad_frame_count, exp_good, exp_bad);
            end
        end
    endtask

    task automatic test_bad_preamble();
        int b0;
        b0 = beat_count;
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 0 || good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
            errors++;
            $display("FAIL bad_preamble got=%0d beats %0d/%0d required=0 beats %0d/%0d", beat_count - b0, good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
        pay.delete();
        send_frame(7, -1, 1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 0 || bad_frame_count !== exp_bad || good_frame_count !== exp_good) begin
            errors++;
            $display("FAIL zero_length got=%0d beats %0d/%0d required=0 beats %0d/%0d", beat_count - b0, good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back({8'(i), i == 0, 1'b0, 1'b0});
            send_byte(8'(i), 1'b1, 1'b0);
        end
        @(negedge clock); #1;
        rgmii_rxd = 4'h4;
        rgmii_rx_ctl = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_good = 16'd0;
        exp_bad = 16'd0;
        checks++;
        if ({rx_data, rx_valid, rx_first, rx_last, rx_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h required=000", {rx_data, rx_valid, rx_first, rx_last, rx_error});
        end
        checks++;
        if ({good_frame_count, bad_frame_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_counters got=%h required=00000000", {good_frame_count, bad_frame_count});
        end
        @(posedge clock); #1;
        rgmii_rxd = 4'h1;
        b0 = beat_count;
        for (int i = 21; i < 24; i++) send_byte(8'(i), 1'b1, 1'b0);
        reset_n = 1'b1;
        for (int i = 24; i < 64; i++) send_byte(8'(i), 1'b1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 0 || good_frame_count !== 16'd0 || bad_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_drop got=%0d beats %0d/%0d required=0 beats 0/0", beat_count - b0, good_frame_count, bad_frame_count);
        end
        fill_counting(64);
        send_frame(7, -1, 1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 64 || good_frame_count !== 16'd1 || bad_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_recover got=%0d beats %0d/%0d required=64 beats 1/0", beat_count - b0, good_frame_count, bad_frame_count);
        end
    endtask

    task automatic test_back_to_back();
        int b0, f0, l0;
        b0 = beat_count;
        f0 = first_count;
        l0 = last_count;
        fill_random(64);
        send_frame(7, -1, 1, 1'b0);
        fill_random(64);
        send_frame(7, -1, 1, 1'b0);
        send_idle(4);
        checks++;
        if (beat_count - b0 !== 128 || first_count - f0 !== 2 || last_count - l0 !== 2) begin
            errors++;
            $display("FAIL b2b_beats got=%0d/%0d/%0d required=128/2/2", beat_count - b0, first_count - f0, last_count - l0);
        end
        checks++;
        if (good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
            errors++;
            $display("FAIL b2b_counters got=%0d/%0d required=%0d/%0d", good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 10; k++) begin
            int n, er;
            n  = $urandom_range(0, 140);
            er = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 150) : -1;
            fill_random(n);
            send_frame($urandom_range(0, 7), er, $urandom_range(1, 3), 1'($urandom));
        end
        send_idle(4);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL random_missing_beats got=%0d left required=0", exp_q.size());
        end
        checks++;
        if (good_frame_count !== exp_good || bad_frame_count !== exp_bad) begin
            errors++;
            $display("FAIL random_counters got=%0d/%0d required=%0d/%0d", good_frame_count, bad_frame_count, exp_good, exp_bad);
        end
    endtask

    initial begin
        test_reset();
        test_nominal_frame();
        test_rx_er();
        test_length_bounds();
        test_bad_preamble();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL final_beats_pending got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
